bus_req_master: RTL and testbench

BUS_REQ_MASTER -- requirements
Module: bus_req_master

---
 rtl/bus_req_master.sv | 138 +++++++++++++
 tb/tb_bus_req_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_req_master.sv
// Arbitrated burst master: latches a command, requests the bus, issues cmd_len beats from a base address.
// Optional grant-wait timeout is built in when BUS_MASTER_TIMEOUT_EN is defined.
module bus_req_master #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int TO_CYC = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              cmd_wr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [3:0]        cmd_len,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_rd,
  output logic              m_req,
  input  logic              m_grant,
  output logic              m_sel,
  output logic              m_wr,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_dout,
  input  logic [DATA_W-1:0] m_din,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, REQ, XFER, RELEASE} state_t;

  state_t              state;
  logic                wr_q;
  logic [ADDR_W-1:0]   base_q;
  logic [3:0]          len_q;
  logic [3:0]          beat;
  logic                last_beat;

`ifdef BUS_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TO_CYC + 1);
  logic [TW-1:0] to_cnt;
  logic          to_hit;
`else
  localparam int unused_to_cyc = TO_CYC;
  assign err = 1'b0;
`endif

  // Beat strobe follows grant combinationally so a dropped grant never issues a beat.
  assign m_sel     = (state == XFER) & m_grant;
  assign m_req     = (state == REQ) | (state == XFER);
  assign busy      = (state != IDLE);
  assign m_wr      = m_sel & wr_q;
  assign wdata_rd  = m_sel & wr_q;
  assign m_dout    = wdata_rd ? wdata : '0;
  assign m_addr    = base_q + ADDR_W'(beat);
  assign last_beat = (beat == len_q - 4'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      wr_q        <= 1'b0;
      base_q      <= '0;
      len_q       <= '0;
      beat        <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      done        <= 1'b0;
`ifdef BUS_MASTER_TIMEOUT_EN
      to_cnt      <= '0;
      to_hit      <= 1'b0;
      err         <= 1'b0;
`endif
    end else begin
      done        <= 1'b0;
      rdata_valid <= m_sel & ~wr_q;
      if (m_sel & ~wr_q) rdata <= m_din;
`ifdef BUS_MASTER_TIMEOUT_EN
      err         <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (start) begin
            if (cmd_len != 4'd0) begin
              wr_q   <= cmd_wr;
              base_q <= cmd_addr;
              len_q  <= cmd_len;
              beat   <= '0;
              state  <= REQ;
`ifdef BUS_MASTER_TIMEOUT_EN
              to_cnt <= '0;
              to_hit <= 1'b0;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        REQ: begin
          if (m_grant) begin
            state <= XFER;
          end
`ifdef BUS_MASTER_TIMEOUT_EN
          else if (to_cnt == TW'(TO_CYC - 1)) begin
            state  <= RELEASE;
            to_hit <= 1'b1;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
`endif
        end
        XFER: begin
          if (m_grant) begin
            beat <= beat + 4'd1;
            if (last_beat) state <= RELEASE;
          end else begin
            // Grant lost mid-burst: beat counter is kept so the burst resumes where it stopped.
            state <= REQ;
`ifdef BUS_MASTER_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        RELEASE: begin
          if (!m_grant) begin
            state <= IDLE;
            done  <= 1'b1;
`ifdef BUS_MASTER_TIMEOUT_EN
            err    <= to_hit;
            to_hit <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_req_master.sv
// Randomized bench for bus_req_master with a transaction-level model of beats, read data and completion.
module tb_bus_req_master;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic          cmd_wr = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [3:0]    cmd_len = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] m_din = '0;
  logic          m_grant = 1'b0;
  logic          wdata_rd, m_req, m_sel, m_wr, rdata_valid, busy, done, err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_dout, rdata;

  int total = 0;
  int bad = 0;

  // model state
  bit            act = 0;
  logic          mwr = 1'b0;
  logic [AW-1:0] mbase = '0;
  int            mlen = 0;
  int            k = 0;
  bit            rv_pend = 0;
  logic [DW-1:0] rd_pend = '0;
  bit            null_pend = 0;
  bit            done_seen = 0;
  bit            fixed_wd = 0;
  bit            to_mode = 0;
  logic          req_d = 1'b0;
  int            rel = 0;
  int            first_req = -1, first_beat = -1, last_beat = -1, done_cyc = -1, nwrd = 0;

  bus_req_master #(.ADDR_W(AW), .DATA_W(DW), .TO_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .wdata(wdata), .wdata_rd(wdata_rd), .m_req(m_req), .m_grant(m_grant),
    .m_sel(m_sel), .m_wr(m_wr), .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din),
    .rdata(rdata), .rdata_valid(rdata_valid), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, m_req, 0);
    chk({tag, "_sel"}, m_sel, 0);
    chk({tag, "_wr"}, m_wr, 0);
    chk({tag, "_wdrd"}, wdata_rd, 0);
    chk({tag, "_rv"}, rdata_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_dout"}, m_dout, 0);
    chk({tag, "_rdata"}, rdata, 0);
  endtask

  // One bus cycle: arbiter grants one cycle after request, gated by g.
  task automatic cycle(input logic st, input logic g);
    logic [AW-1:0] ea;
    bit exp_null;
    @(posedge clk); #1;
    rel++;
    start   = st;
    m_grant = g & req_d;
    ea      = mbase + AW'(k);
    wdata   = fixed_wd ? (DW'(16'hA1) + DW'(k)) : DW'($urandom);
    m_din   = 16'h5000 + {8'h00, ea};
    #3;
    if (m_req && first_req < 0) first_req = rel;
    if (!m_grant) chk("sel_without_grant", m_sel, 0);
    if (m_sel) begin
      if (first_beat < 0) first_beat = rel;
      last_beat = rel;
      chk("beat_addr", m_addr, ea);
      chk("beat_wr", m_wr, mwr);
      chk("beat_wdata_rd", wdata_rd, mwr);
      if (mwr) begin
        chk("beat_dout", m_dout, wdata);
        nwrd++;
      end
      k++;
      chk("beat_overrun", k <= mlen, 1);
    end else begin
      chk("wdata_rd_idle", wdata_rd, 0);
    end
    chk("rdata_valid", rdata_valid, rv_pend);
    if (rv_pend) chk("rdata", rdata, rd_pend);
    exp_null  = null_pend;
    null_pend = 0;
    if (exp_null) begin
      chk("null_done", done, 1);
      done_seen = done;
      done_cyc  = rel;
    end else if (act) begin
      if (done) begin
        if (to_mode) begin
          chk("to_err", err, 1);
          chk("to_window", (rel >= TO) && (rel <= TO + 4), 1);
        end else begin
          chk("done_beats", k, mlen);
        end
        act = 0;
        done_seen = 1;
        done_cyc = rel;
      end
    end else begin
      chk("idle_no_done", done, 0);
    end
    if (!(done && to_mode)) chk("err_low", err, 0);
    chk("busy", busy, act);
    if (!act) chk("req_idle", m_req, 0);
    rv_pend = m_sel & ~mwr;
    rd_pend = m_din;
    if (st && !act) begin
      if (cmd_len != 4'd0) begin
        act = 1; mwr = cmd_wr; mbase = cmd_addr; mlen = int'(cmd_len); k = 0;
      end else begin
        null_pend = 1;
      end
    end
    req_d = m_req;
  endtask

  // mode 0: grant always, 1: drop 2 cycles after beat 1, 2: random, 3: never
  task automatic run_cmd(input logic w, input logic [AW-1:0] a, input logic [3:0] l,
                         input int mode, input int spur_at, input bit fixed);
    int   drop_left;
    bit   dropped;
    logic g;
    drop_left = 0; dropped = 0;
    fixed_wd = fixed; rel = -1; done_seen = 0; done_cyc = -1;
    first_req = -1; first_beat = -1; last_beat = -1; nwrd = 0;
    cmd_wr = w; cmd_addr = a; cmd_len = l;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 300 && !done_seen; i++) begin
      g = 1'b1;
      if (mode == 1 && k == 2 && !dropped) begin dropped = 1; drop_left = 2; end
      if (drop_left > 0) begin g = 1'b0; drop_left--; end
      else if (mode == 2) g = ($urandom_range(0, 3) != 0);
      else if (mode == 3) g = 1'b0;
      if (rel + 1 == spur_at) begin
        cmd_wr = ~w; cmd_addr = a + 8'h40; cmd_len = 4'd5;
        cycle(1'b1, g);
      end else begin
        cycle(1'b0, g);
      end
    end
    if (!done_seen) chk("done_bound", 0, 1);
  endtask

  task automatic do_reset();
    #3;
    reset_n = 1'b0;
    #1;
    chk_zero("rst_async");
    act = 0; k = 0; rv_pend = 0; null_pend = 0; req_d = 1'b0; m_grant = 1'b0; start = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk_zero("rst_init");
    #19;
    reset_n = 1'b1;

    // directed write burst with fixed data
    run_cmd(1'b1, 8'h10, 4'd3, 0, 0, 1);
    chk("wr_first_req", first_req, 1);
    chk("wr_first_beat", first_beat, 3);
    chk("wr_last_beat", last_beat, 5);
    chk("wr_done_cyc", done_cyc, 8);
    chk("wr_wdata_rd_cnt", nwrd, 3);
    cycle(1'b0, 1'b1);

    // directed read burst wrapping the address space
    run_cmd(1'b0, 8'hFE, 4'd4, 0, 0, 0);
    chk("rd_first_beat", first_beat, 3);
    chk("rd_last_beat", last_beat, 6);
    chk("rd_done_cyc", done_cyc, 9);
    cycle(1'b0, 1'b1);

    // null command
    run_cmd(1'b1, 8'h33, 4'd0, 0, 0, 0);
    chk("null_done_cyc", done_cyc, 1);
    chk("null_no_req", first_req, 32'hFFFF_FFFF);
    cycle(1'b0, 1'b1);

    // start while busy is ignored
    run_cmd(1'b1, 8'h20, 4'd3, 0, 4, 0);
    chk("spur_done_cyc", done_cyc, 8);
    chk("spur_wdata_rd_cnt", nwrd, 3);
    cycle(1'b0, 1'b1);

    // grant dropped mid-burst
    run_cmd(1'b1, 8'h80, 4'd4, 1, 0, 0);
    chk("drop_wdata_rd_cnt", nwrd, 4);
    chk("drop_last_beat_late", last_beat > 6, 1);
    cycle(1'b0, 1'b1);

    // reset mid-transfer
    fixed_wd = 0; rel = -1; done_seen = 0;
    cmd_wr = 1'b1; cmd_addr = 8'h40; cmd_len = 4'd8;
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 20 && k < 3; i++) cycle(1'b0, 1'b1);
    chk("mid_xfer_reached", k, 3);
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1);
    chk("post_rst_no_done", done_seen, 0);

`ifdef BUS_MASTER_TIMEOUT_EN
    to_mode = 1;
    run_cmd(1'b0, 8'h05, 4'd2, 3, 0, 0);
    chk("to_done_cyc", done_cyc, TO + 2);
    to_mode = 0;
    cycle(1'b0, 1'b1);
`else
    rel = -1;
    cmd_wr = 1'b0; cmd_addr = 8'h05; cmd_len = 4'd2;
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 3 * TO; i++) cycle(1'b0, 1'b0);
    chk("wait_busy", busy, 1);
    chk("wait_req", m_req, 1);
    do_reset();
    cycle(1'b0, 1'b1);
`endif

    // randomized commands with random grant stalls
    for (int n = 0; n < 25; n++) begin
      logic [3:0] l;
      l = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_cmd(1'($urandom_range(0, 1)), AW'($urandom), l, 2, (n % 4 == 0) ? 3 : 0, 0);
      for (int j = 0; j < int'($urandom_range(1, 3)); j++) cycle(1'b0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
